// File: rtl/svf_audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : svf_audio_pkg
// Description : Shared constants and helpers for the state-variable-filter
//               audio path (mix, saturation, PWM DAC).
// Revision    : 1.0 - initial release
// ============================================================================
package svf_audio_pkg;

    // Idle / zero-signal PWM duty (signed 0 mapped to offset binary)
    localparam logic [7:0] MIDSCALE   = 8'h80;
    // PWM period in clocks for an 8-bit counter
    localparam int         PWM_PERIOD = 256;

    // Bit positions of the response enables in the mode word
    localparam int MODE_LP = 0;
    localparam int MODE_BP = 1;
    localparam int MODE_HP = 2;

    // Clamp a 10-bit signed accumulator into the 8-bit signed sample range
    function automatic logic [7:0] sat8(input logic signed [9:0] x);
        logic [7:0] r;
        if (x > 10'sd127) begin
            r = 8'h7F;
        end else if (x < -10'sd128) begin
            r = 8'h80;
        end else begin
            r = x[7:0];
        end
        return r;
    endfunction

endpackage : svf_audio_pkg
`default_nettype wire

// File: rtl/svf_mix_sat.sv
`default_nettype none
// ============================================================================
// Module      : svf_mix_sat
// Description : Combinational response mixer. Sums the enabled filter
//               outputs, saturates to 8 bits, applies (volume+1)/16 gain
//               with floor rounding and converts to an unsigned PWM duty.
// Revision    : 1.0 - initial release
// ============================================================================
module svf_mix_sat
    import svf_audio_pkg::*;
(
    input  logic [7:0] hp,
    input  logic [7:0] lp,
    input  logic [7:0] bp,
    input  logic [2:0] mode,
    input  logic [3:0] volume,
    output logic [7:0] duty
);

    logic signed [9:0]  w_lp_ext;
    logic signed [9:0]  w_bp_ext;
    logic signed [9:0]  w_hp_ext;
    logic signed [9:0]  w_sum;
    logic        [7:0]  w_mix;
    logic signed [12:0] w_mix_ext;
    logic signed [12:0] w_gain;
    logic signed [12:0] w_prod;
    logic        [7:0]  w_scaled;
    logic               w_unused_bits;

    // Sign-extend each enabled response; a disabled response contributes 0.
    // Three 8-bit values never exceed +/-384, so 10 bits cannot overflow.
    always_comb begin
        w_lp_ext = mode[MODE_LP] ? {{2{lp[7]}}, lp} : 10'sd0;
        w_bp_ext = mode[MODE_BP] ? {{2{bp[7]}}, bp} : 10'sd0;
        w_hp_ext = mode[MODE_HP] ? {{2{hp[7]}}, hp} : 10'sd0;
        w_sum    = w_lp_ext + w_bp_ext + w_hp_ext;
        w_mix    = sat8(w_sum);
    end

    // Gain stage: mix * (volume+1) fits 13 bits signed (|-128*16| = 2048).
    // Dropping the low 4 product bits of a two's-complement value is an
    // arithmetic shift with floor rounding, and the result always fits
    // back into 8 bits because the gain never exceeds 1.0.
    always_comb begin
        w_mix_ext = {{5{w_mix[7]}}, w_mix};
        w_gain    = {9'd0, volume} + 13'sd1;
        w_prod    = w_mix_ext * w_gain;
        w_scaled  = w_prod[11:4];
        // Offset-binary duty: adding 128 to a signed byte flips its MSB
        duty      = {~w_scaled[7], w_scaled[6:0]};
    end

    // Product bits below the shift point and the redundant sign bit
    assign w_unused_bits = ^{w_prod[12], w_prod[3:0]};

endmodule : svf_mix_sat
`default_nettype wire

// File: rtl/svf_mix_pwm.sv
`default_nettype none
// ============================================================================
// Module      : svf_mix_pwm
// Description : Output sink for the 8-bit state variable filter. Mixes the
//               selected responses on each sample strobe, buffers one sample
//               and drives a fixed-period PWM DAC whose duty only changes at
//               period boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module svf_mix_pwm
    import svf_audio_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_valid,
    input  logic [7:0] audio_in_hp,
    input  logic [7:0] audio_in_lp,
    input  logic [7:0] audio_in_bp,
    input  logic [2:0] mode,
    input  logic [3:0] volume,
    input  logic       overrun_clr,
    output logic       pwm_out,
    output logic       sample_taken,
    output logic       overrun
);

    localparam logic [PWM_BITS-1:0] c_CNT_MAX = {PWM_BITS{1'b1}};

    logic [PWM_BITS-1:0] r_cnt;
    logic [7:0]          r_duty_active;
    logic [7:0]          r_pending;
    logic                r_pending_vld;

    logic [7:0]          w_duty;
    logic                w_boundary;
    logic                w_load;
    logic                w_overrun_set;

    // Mix, saturate, scale and convert the current filter outputs
    svf_mix_sat u_mix_sat (
        .hp     (audio_in_hp),
        .lp     (audio_in_lp),
        .bp     (audio_in_bp),
        .mode   (mode),
        .volume (volume),
        .duty   (w_duty)
    );

    // A pending sample is swapped in only on the last clock of a period, so
    // a strobe in that same cycle is never an overrun: the old sample leaves
    // as the new one arrives.
    always_comb begin
        w_boundary    = (r_cnt == c_CNT_MAX);
        w_load        = w_boundary && r_pending_vld;
        w_overrun_set = sample_valid && r_pending_vld && !w_load;
    end

    // Free-running PWM period counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // One-deep sample buffer; newest strobe always wins the pending slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending     <= MIDSCALE;
            r_pending_vld <= 1'b0;
        end else begin
            if (sample_valid) begin
                r_pending     <= w_duty;
                r_pending_vld <= 1'b1;
            end else if (w_load) begin
                r_pending_vld <= 1'b0;
            end
        end
    end

    // Active duty register updated only at period boundaries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty_active <= MIDSCALE;
            sample_taken  <= 1'b0;
        end else begin
            sample_taken <= w_load;
            if (w_load) begin
                r_duty_active <= r_pending;
            end
        end
    end

    // Registered PWM comparator; high for duty_active clocks per period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= (r_cnt < r_duty_active);
        end
    end

    // Sticky overrun flag; a new overrun takes priority over the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (w_overrun_set) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule : svf_mix_pwm
`default_nettype wire

// File: tb/tb_svf_mix_pwm.sv
`default_nettype none
// ============================================================================
// Module      : tb_svf_mix_pwm
// Description : Self-checking bench for svf_mix_pwm. Vector table for the
//               mix/volume/duty path plus directed sequences for overrun,
//               boundary strobes and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_svf_mix_pwm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_valid = 1'b0;
    logic [7:0] audio_in_hp = 8'd0;
    logic [7:0] audio_in_lp = 8'd0;
    logic [7:0] audio_in_bp = 8'd0;
    logic [2:0] mode = 3'd0;
    logic [3:0] volume = 4'd0;
    logic       overrun_clr = 1'b0;
    logic       pwm_out;
    logic       sample_taken;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] mode;
        logic [7:0] hp;
        logic [7:0] lp;
        logic [7:0] bp;
        logic [3:0] vol;
        int         exp_duty;
    } vec_t;

    vec_t vecs[11];

    svf_mix_pwm #(.PWM_BITS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .audio_in_hp  (audio_in_hp),
        .audio_in_lp  (audio_in_lp),
        .audio_in_bp  (audio_in_bp),
        .mode         (mode),
        .volume       (volume),
        .overrun_clr  (overrun_clr),
        .pwm_out      (pwm_out),
        .sample_taken (sample_taken),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one strobe at a negedge; returns at the following negedge
    task automatic strobe(input logic [2:0] m, input logic [7:0] hp,
                          input logic [7:0] lp, input logic [7:0] bp,
                          input logic [3:0] v);
        mode         = m;
        audio_in_hp  = hp;
        audio_in_lp  = lp;
        audio_in_bp  = bp;
        volume       = v;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    // Count high clocks and sample_taken pulses over one full period
    task automatic measure(output int highs, output int takens);
        highs  = 0;
        takens = 0;
        repeat (256) begin
            @(negedge clk);
            if (pwm_out)      highs++;
            if (sample_taken) takens++;
        end
    endtask

    // Bounded wait for a sample_taken pulse
    task automatic wait_taken(output int found);
        found = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (sample_taken) begin
                found = 1;
                break;
            end
        end
    endtask

    initial begin
        int highs, takens, found;

        //               mode    hp      lp      bp      vol    duty
        vecs[0]  = '{3'b001, 8'd0,   8'd64,  8'd0,   4'd15, 192};
        vecs[1]  = '{3'b111, 8'd100, 8'd100, 8'd100, 4'd15, 255};
        vecs[2]  = '{3'b111, 8'h9C,  8'h9C,  8'h9C,  4'd15, 0};
        vecs[3]  = '{3'b001, 8'd0,   8'h80,  8'd0,   4'd7,  64};
        vecs[4]  = '{3'b001, 8'd0,   8'hFF,  8'd0,   4'd0,  127};
        vecs[5]  = '{3'b000, 8'd50,  8'd50,  8'd50,  4'd15, 128};
        vecs[6]  = '{3'b010, 8'd99,  8'd99,  8'd40,  4'd3,  138};
        vecs[7]  = '{3'b100, 8'hCE,  8'd0,   8'd0,   4'd15, 78};
        vecs[8]  = '{3'b101, 8'd30,  8'hBA,  8'd0,   4'd9,  103};
        vecs[9]  = '{3'b011, 8'd0,   8'd100, 8'd50,  4'd11, 223};
        vecs[10] = '{3'b110, 8'hF9,  8'd0,   8'd0,   4'd2,  126};

        // Reset values visible while rst is held
        #1;
        check("reset_pwm_out", int'(pwm_out), 0);
        check("reset_sample_taken", int'(sample_taken), 0);
        check("reset_overrun", int'(overrun), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        measure(highs, takens);
        check("idle_duty", highs, 128);
        check("idle_takens", takens, 0);
        check("idle_overrun", int'(overrun), 0);

        // Table-driven mix/volume/duty vectors; inputs are scrambled right
        // after the strobe so only the strobed values may matter
        for (int k = 0; k < 11; k++) begin
            strobe(vecs[k].mode, vecs[k].hp, vecs[k].lp, vecs[k].bp, vecs[k].vol);
            mode        = ~vecs[k].mode;
            volume      = ~vecs[k].vol;
            audio_in_hp = ~vecs[k].hp;
            audio_in_lp = ~vecs[k].lp;
            audio_in_bp = ~vecs[k].bp;
            wait_taken(found);
            check($sformatf("vec%0d_taken", k), found, 1);
            measure(highs, takens);
            check($sformatf("vec%0d_duty", k), highs, vecs[k].exp_duty);
            check($sformatf("vec%0d_extra_takens", k), takens, 0);
        end
        check("no_overrun_after_vectors", int'(overrun), 0);

        // Two strobes in one period: newest wins, overrun set
        strobe(3'b001, 8'd0, 8'd10, 8'd0, 4'd15);
        strobe(3'b001, 8'd0, 8'd20, 8'd0, 4'd15);
        check("overrun_set", int'(overrun), 1);
        wait_taken(found);
        check("overrun_taken", found, 1);
        measure(highs, takens);
        check("overrun_newest_duty", highs, 148);
        check("overrun_sticky", int'(overrun), 1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("overrun_cleared", int'(overrun), 0);

        // Now in the cnt==1 cycle: strobe A, then strobe B at cnt==255
        strobe(3'b001, 8'd0, 8'd30, 8'd0, 4'd15);
        repeat (253) @(negedge clk);
        strobe(3'b001, 8'd0, 8'hE2, 8'd0, 4'd15);
        check("boundary_taken", int'(sample_taken), 1);
        check("boundary_no_overrun", int'(overrun), 0);
        measure(highs, takens);
        check("boundary_first_duty", highs, 158);
        check("boundary_second_taken", takens, 1);
        measure(highs, takens);
        check("boundary_second_duty", highs, 98);
        check("boundary_overrun_after", int'(overrun), 0);

        // Clear and a fresh overrun in the same cycle: set wins
        strobe(3'b001, 8'd0, 8'd5, 8'd0, 4'd15);
        overrun_clr = 1'b1;
        strobe(3'b001, 8'd0, 8'd6, 8'd0, 4'd15);
        overrun_clr = 1'b0;
        check("clr_vs_set", int'(overrun), 1);

        // Asynchronous reset mid-period with a pending sample outstanding
        repeat (3) @(negedge clk);
        check("pre_reset_pwm_high", int'(pwm_out), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_pwm_out", int'(pwm_out), 0);
        check("async_reset_overrun", int'(overrun), 0);
        check("async_reset_taken", int'(sample_taken), 0);
        @(negedge clk);
        rst = 1'b0;
        takens = 0;
        repeat (300) begin
            @(negedge clk);
            if (sample_taken) takens++;
        end
        check("pending_discarded", takens, 0);
        measure(highs, takens);
        check("post_reset_duty", highs, 128);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_svf_mix_pwm
`default_nettype wire
